// File: rtl/colour_pkg.sv
// colour_pkg: definitions shared by the colour sensor and the colour message transmitter.
//   - sensor colour codes (COL_*)
//   - ASCII characters used in the 4-byte telemetry message (ASCII_*)
//   - transmitter FSM state encoding (state_e)
//   - helpers mapping a colour code / node number to its message character
package colour_pkg;

    localparam logic [2:0] COL_WHITE = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b001;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b011;

    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_G    = 8'h47;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_X    = 8'h58;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitValid,
        StLoad,
        StSend,
        StFinish
    } state_e;

    // Codes with bit 2 set are not valid colours and report as 'X'.
    function automatic logic [7:0] colour_char(input logic [2:0] code);
        logic [7:0] ch;
        case (code)
            COL_WHITE: ch = ASCII_W;
            COL_RED:   ch = ASCII_R;
            COL_GREEN: ch = ASCII_G;
            COL_BLUE:  ch = ASCII_B;
            default:   ch = ASCII_X;
        endcase
        return ch;
    endfunction

    // Single hex-style digit: 0-9 then A-F.
    function automatic logic [7:0] node_char(input logic [3:0] id);
        if (id < 4'd10) begin
            return ASCII_ZERO + {4'b0000, id};
        end
        return ASCII_A + {4'b0000, id - 4'd10};
    endfunction

endpackage

// File: rtl/colour_msg_tx_if.sv
// colour_msg_tx_if: bundle between the colour message transmitter, the colour sensor and the
// path/message controller.
//   trigger  : request to measure and report (controller -> tx)
//   node_id  : node number to report (controller -> tx)
//   color    : sensor colour code (sensor -> tx)
//   valid    : sensor result-ready level (sensor -> tx)
//   measure  : restart request to the sensor (tx -> sensor)
//   tx       : UART serial line, idle high (tx -> XBee)
//   busy     : message in progress (tx -> controller)
//   msg_done : one-cycle completion pulse (tx -> controller)
// Modports: master = environment side, slave = transmitter side.
interface colour_msg_tx_if;
    logic       trigger;
    logic [3:0] node_id;
    logic [2:0] color;
    logic       valid;
    logic       measure;
    logic       tx;
    logic       busy;
    logic       msg_done;

    modport master (
        output trigger, node_id, color, valid,
        input  measure, tx, busy, msg_done
    );

    modport slave (
        input  trigger, node_id, color, valid,
        output measure, tx, busy, msg_done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 UART transmitter for one byte.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load data and begin a frame (accepted when idle or while done is high)
//   data     : byte to send, LSB first
//   tx       : serial output, idle high
//   done     : one-cycle pulse during the final cycle of the stop bit
// Parameter BIT_DIV: clock cycles per bit (>= 2).
module uart_tx_byte #(
    parameter int unsigned BIT_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] DivLast = CW'(BIT_DIV - 1);

    logic          active_q;
    logic [CW-1:0] div_q;
    logic [3:0]    bit_q;
    logic [9:0]    frame_q;
    logic          tx_q;

    // done coincides with the last stop-bit cycle so a chained start bit follows with no gap.
    assign done = active_q && (bit_q == 4'd9) && (div_q == DivLast);
    assign tx   = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= 4'd0;
            frame_q  <= 10'd0;
            tx_q     <= 1'b1;
        end else if (start && (!active_q || done)) begin
            frame_q  <= {1'b1, data, 1'b0};
            tx_q     <= 1'b0;
            bit_q    <= 4'd0;
            div_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (div_q == DivLast) begin
                div_q <= '0;
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    frame_q <= {1'b1, frame_q[9:1]};
                    tx_q    <= frame_q[1];
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/colour_msg_tx.sv
// colour_msg_tx: on trigger, requests a colour measurement, latches the result and sends the
// 4-byte ASCII message "C", colour letter, node digit, "#" over an 8N1 UART.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : colour_msg_tx_if.slave (trigger/node_id/color/valid in; measure/tx/busy/msg_done out)
// Parameters: BIT_DIV cycles per UART bit; TIMEOUT_CYCLES sensor wait limit.
// Optional macro COLOUR_TIMEOUT_EN: abandon the sensor wait after TIMEOUT_CYCLES and report
// 'E' as the colour letter. Without it the block waits for valid indefinitely.
module colour_msg_tx
    import colour_pkg::*;
#(
    parameter int unsigned BIT_DIV        = 434,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic            clk,
    input logic            rst,
    colour_msg_tx_if.slave bus
);

    state_e     state_q;
    logic [3:0] node_q;
    logic [2:0] color_q;
    logic [7:0] msg_q [4];
    logic [1:0] byte_q;
    logic       start_q;
    logic       measure_q;
    logic       busy_q;
    logic       done_q;
    logic       timed_out;

    logic       uart_start;
    logic       uart_done;
    logic [7:0] uart_data;

`ifdef COLOUR_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    assign tmo_hit = (tmo_q == TmoLast);
`else
    logic unused_timeout;
    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // First byte is kicked off from the registered start; later bytes chain on the done pulse.
    assign uart_start = start_q || ((state_q == StSend) && uart_done && (byte_q != 2'd3));
    assign uart_data  = msg_q[start_q ? 2'd0 : byte_q + 2'd1];

    assign bus.measure  = measure_q;
    assign bus.busy     = busy_q;
    assign bus.msg_done = done_q;

    uart_tx_byte #(
        .BIT_DIV(BIT_DIV)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .start(uart_start),
        .data (uart_data),
        .tx   (bus.tx),
        .done (uart_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            node_q    <= 4'd0;
            color_q   <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                msg_q[i] <= 8'h00;
            end
            byte_q    <= 2'd0;
            start_q   <= 1'b0;
            measure_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef COLOUR_TIMEOUT_EN
            tmo_q     <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
`ifdef COLOUR_TIMEOUT_EN
            if ((state_q == StReq) || (state_q == StWaitValid)) begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
            case (state_q)
                StIdle: begin
                    if (bus.trigger) begin
                        node_q    <= bus.node_id;
                        busy_q    <= 1'b1;
                        measure_q <= 1'b1;
                        state_q   <= StReq;
`ifdef COLOUR_TIMEOUT_EN
                        tmo_q     <= '0;
                        timed_out <= 1'b0;
`endif
                    end
                end
                StReq: begin
                    // measure stays up until the sensor acknowledges by dropping valid.
                    if (!bus.valid) begin
                        measure_q <= 1'b0;
                        state_q   <= StWaitValid;
                    end
`ifdef COLOUR_TIMEOUT_EN
                    if (tmo_hit) begin
                        measure_q <= 1'b0;
                        timed_out <= 1'b1;
                        state_q   <= StLoad;
                    end
`endif
                end
                StWaitValid: begin
                    if (bus.valid) begin
                        color_q <= bus.color;
                        state_q <= StLoad;
                    end
`ifdef COLOUR_TIMEOUT_EN
                    else if (tmo_hit) begin
                        timed_out <= 1'b1;
                        state_q   <= StLoad;
                    end
`endif
                end
                StLoad: begin
                    msg_q[0] <= ASCII_C;
                    msg_q[1] <= timed_out ? ASCII_E : colour_char(color_q);
                    msg_q[2] <= node_char(node_q);
                    msg_q[3] <= ASCII_HASH;
                    byte_q   <= 2'd0;
                    start_q  <= 1'b1;
                    state_q  <= StSend;
                end
                StSend: begin
                    if (uart_done) begin
                        if (byte_q == 2'd3) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFinish;
                        end else begin
                            byte_q <= byte_q + 2'd1;
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_colour_msg_tx.sv
// tb_colour_msg_tx: self-checking bench for colour_msg_tx (BIT_DIV=4, TIMEOUT_CYCLES=50).
// A behavioural sensor answers measure, a UART receiver decodes tx, and expected messages
// come from the character rules of the message format.
module tb_colour_msg_tx;

    localparam int unsigned Div = 4;
    localparam int unsigned Tmo = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    colour_msg_tx_if bus ();

    colour_msg_tx #(
        .BIT_DIV       (Div),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected message character from the format rules.
    function automatic logic [7:0] model_byte(input int idx, input logic [2:0] col,
                                              input logic [3:0] node, input bit tmo);
        string letters;
        letters = "WRGB";
        case (idx)
            0: return 8'h43;                                  // 'C'
            1: begin
                if (tmo) return 8'h45;                        // 'E'
                if (col > 3) return 8'h58;                    // 'X'
                return 8'(letters[int'(col)]);
            end
            2: return (node < 10) ? 8'(48 + int'(node)) : 8'(65 + int'(node) - 10);
            default: return 8'h23;                            // '#'
        endcase
    endfunction

    // Sensor model: after seeing measure (plus lag cycles) drop valid, then reassert after
    // s_delay cycles with the new colour unless hold_low is set.
    logic [2:0]  s_color   = 3'd0;
    int          lag_left  = 0;
    int          s_delay   = 1;
    int          rdy_cnt   = 0;
    bit          hold_low  = 1'b0;
    int unsigned valid_cyc = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (bus.valid && bus.measure) begin
            if (lag_left > 0) begin
                lag_left--;
            end else begin
                bus.valid = 1'b0;
                rdy_cnt   = s_delay;
            end
        end else if (!bus.valid && rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0 && !hold_low) begin
                bus.color = s_color;
                bus.valid = 1'b1;
                valid_cyc = cyc;
            end
        end
    end

    // Cycles with measure high.
    int meas_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (bus.measure === 1'b1) meas_cnt++;
    end

    // UART receiver, sampling mid-bit on falling clock edges.
    logic [7:0]  rx_q [$];
    int unsigned rx_start [$];
    logic [7:0]  mon_b;
    int unsigned mon_sc;
    bit          mon_bad;

    initial forever begin
        @(negedge clk);
        if (!rst && bus.tx === 1'b0) begin
            mon_sc  = cyc;
            mon_bad = 1'b0;
            @(negedge clk);
            if (rst || bus.tx !== 1'b0) mon_bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
                repeat (Div) @(negedge clk);
                if (rst) mon_bad = 1'b1;
                mon_b[i] = bus.tx;
            end
            repeat (Div) @(negedge clk);
            if (rst || bus.tx !== 1'b1) mon_bad = 1'b1;
            repeat (Div - 2) @(negedge clk);
            if (!mon_bad) begin
                rx_q.push_back(mon_b);
                rx_start.push_back(mon_sc);
            end
        end
    end

    task automatic run_msg(input logic [2:0] col, input logic [3:0] node, input int lag,
                           input int dly, input bit pre_low, input bit inj_send,
                           input bit inj_fin, input bit tmo);
        int unsigned trig_cyc;
        int unsigned done_cyc;
        int          n;
        int          early;
        bit          injected;
        rx_q.delete();
        rx_start.delete();
        meas_cnt  = 0;
        s_color   = col;
        lag_left  = lag;
        s_delay   = dly;
        hold_low  = tmo;
        valid_cyc = 0;
        if (pre_low) begin
            bus.valid = 1'b0;
            rdy_cnt   = dly + 3;
        end
        bus.node_id = node;
        bus.trigger = 1'b1;
        trig_cyc    = cyc + 1;
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.node_id = 4'($urandom);
        check("busy_rise", {31'd0, bus.busy}, 1);
        n        = 0;
        early    = 0;
        injected = 1'b0;
        while (bus.msg_done !== 1'b1 && n < 800) begin
            @(negedge clk);
            n++;
            bus.trigger = 1'b0;
            if (bus.msg_done !== 1'b1) begin
                if (bus.busy !== 1'b1) early++;
                if (inj_send && !injected && rx_q.size() == 1) begin
                    bus.trigger = 1'b1;
                    injected    = 1'b1;
                end
            end
        end
        done_cyc = cyc;
        check("msg_done_seen", {31'd0, bus.msg_done}, 1);
        check("busy_clear_with_done", {31'd0, bus.busy}, 0);
        check("busy_no_early_drop", early, 0);
        if (inj_fin) bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        check("msg_done_one_cycle", {31'd0, bus.msg_done}, 0);
        check("byte_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("byte%0d", i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hdead,
                  {24'd0, model_byte(i, col, node, tmo)});
        end
        if (rx_start.size() == 4) begin
            check("msg_length", done_cyc - rx_start[0], 40 * Div);
            check("bytes_back_to_back", rx_start[3] - rx_start[0], 30 * Div);
            if (tmo) check("timeout_to_start", rx_start[0] - trig_cyc, Tmo + 2);
            else     check("valid_to_start", rx_start[0] - valid_cyc, 3);
        end
        check("measure_width", meas_cnt, (pre_low || tmo) ? 1 : lag + 1);
        repeat (20) @(negedge clk);
        check("idle_after", {29'd0, bus.busy, bus.tx, bus.measure}, 3'b010);
        check("no_extra_bytes", rx_q.size(), 4);
        if (tmo) begin
            hold_low  = 1'b0;
            bus.color = col;
            bus.valid = 1'b1;
        end
    endtask

    task automatic reset_mid_msg();
        int          n;
        int unsigned s;
        s_color     = 3'b010;
        lag_left    = 0;
        s_delay     = 2;
        hold_low    = 1'b0;
        bus.node_id = 4'd5;
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        n = 0;
        while (bus.tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_start_seen", {31'd0, bus.tx}, 0);
        s = cyc;
        // Middle of bit 5 (data bit 4) of the second byte.
        while (cyc < s + 40 + 5 * Div + 1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx", {31'd0, bus.tx}, 1);
        check("rst_async_busy", {31'd0, bus.busy}, 0);
        check("rst_async_measure", {31'd0, bus.measure}, 0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        rdy_cnt   = 0;
        bus.valid = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_idle_busy", {31'd0, bus.busy}, 0);
        check("rst_idle_tx", {31'd0, bus.tx}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.trigger = 1'b0;
        bus.node_id = 4'd0;
        bus.color   = 3'd0;
        bus.valid   = 1'b1;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, bus.tx}, 1);
        check("reset_busy", {31'd0, bus.busy}, 0);
        check("reset_measure", {31'd0, bus.measure}, 0);
        check("reset_msg_done", {31'd0, bus.msg_done}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_msg(3'b001, 4'd3,  1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_msg(3'b011, 4'd12, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_msg(3'b101, 4'd0,  2, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_msg(3'b000, 4'd9,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_msg(3'b010, 4'd15, 0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        reset_mid_msg();
        run_msg(3'b011, 4'd10, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_msg(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef COLOUR_TIMEOUT_EN
        run_msg(3'b001, 4'd7, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        begin
            int bad;
            bad         = 0;
            s_color     = 3'b001;
            lag_left    = 0;
            s_delay     = 1;
            hold_low    = 1'b1;
            bus.node_id = 4'd7;
            bus.trigger = 1'b1;
            @(negedge clk);
            bus.trigger = 1'b0;
            repeat (1000) begin
                @(negedge clk);
                if (bus.tx !== 1'b1 || bus.busy !== 1'b1) bad++;
            end
            check("wait_forever", bad, 0);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst       = 1'b0;
            hold_low  = 1'b0;
            rdy_cnt   = 0;
            bus.valid = 1'b1;
            repeat (3) @(negedge clk);
        end
`endif
        run_msg(3'b000, 4'd1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/colour_msg_tx.md
Name: colour_msg_tx

Overview:
- Consumer end of the colour sensor's measure/valid handshake.
- On a trigger it requests one colour measurement, waits for the sensor's result and latches it.
- It then serialises a 4-byte ASCII message over an 8N1 UART line to the telemetry (XBee) link.
- Sits between the colour sensor and the top-level path/message controller.

Parameters:
- BIT_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- TIMEOUT_CYCLES, 2000000, max cycles to wait for valid; used only with COLOUR_TIMEOUT_EN.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- trigger  in  1  single-cycle request to measure and report.
- node_id  in  4  node number, sampled on accepted trigger.
- color  in  3  colour code from sensor: 000 white, 001 red, 010 green, 011 blue, 1xx invalid.
- valid  in  1  sensor result-ready level.
- measure  out  1  restart request to the sensor.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from accepted trigger until message complete.
- msg_done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset values: measure=0, tx=1, busy=0, msg_done=0, FSM=IDLE, all counters and latches 0.
- Reset mid-message truncates the frame immediately; tx returns to 1.
- FSM states are IDLE, REQ, WAIT_VALID, LOAD, SEND, FINISH.
- IDLE:
  - trigger=1 → latch node_id, busy=1, go to REQ.
  - trigger while busy is ignored (no queueing).
- REQ:
  - measure=1 held while valid=1; the sensor drops valid one cycle after seeing measure.
  - On the first cycle valid=0: measure=0 next cycle, go to WAIT_VALID.
  - If valid is already 0 on REQ entry (sensor mid-measurement), measure is high for exactly 1 cycle, then WAIT_VALID; the pending result is accepted.
- WAIT_VALID:
  - On valid=1: latch color, go to LOAD.
  - No timeout unless COLOUR_TIMEOUT_EN.
- LOAD: build the message bytes.
  - B0 = 'C' (0x43).
  - B1 = 'W'/'R'/'G'/'B' (0x57/0x52/0x47/0x42) for 000/001/010/011; 'X' (0x58) for 1xx.
  - B2 = node_id<10 ? 0x30+node_id : 0x41+(node_id−10).
  - B3 = '#' (0x23).
- SEND:
  - Bytes are sent B0..B3 in order.
  - Each byte: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly BIT_DIV cycles.
  - The next start bit follows the previous stop bit with no idle gap.
  - Whole message is 40·BIT_DIV cycles.
- FINISH: msg_done=1 for one cycle, busy=0 in the same cycle, return to IDLE. A trigger in that cycle is ignored.
- Latency: trigger sampled at edge 0 → busy=1 after edge 0.
  - tx start bit of B0 begins 2 cycles after valid is latched.
- Widths: bit-divider counter is ceil(log2(BIT_DIV)) bits and wraps at BIT_DIV−1; bit index 0..9; byte index 0..3.

Optional Feature:
- Macro: COLOUR_TIMEOUT_EN.
- When defined:
  - A counter runs in REQ and WAIT_VALID, cleared on REQ entry.
  - Reaching TIMEOUT_CYCLES without valid → go to LOAD with B1 = 'E' (0x45).
  - measure is forced to 0.
  - The message is sent normally.
- When undefined: no counter is synthesised and the block waits indefinitely.

Decomposition:
- Shared package colour_pkg holds:
  - colour code constants (COL_WHITE=3'b000, COL_RED=3'b001, COL_GREEN=3'b010, COL_BLUE=3'b011);
  - the ASCII constants above;
  - FSM state encoding.
- The colour sensor also imports the colour codes from colour_pkg.
- One natural sub-module: uart_tx_byte.
  - Ports: clk, rst, start, data[7:0], tx, done.
  - Parameter: BIT_DIV.
  - done is a 1-cycle pulse at the end of the stop bit.
  - start accepted while done is high enables back-to-back bytes.

Test Plan (BIT_DIV=4, TIMEOUT_CYCLES=50):
- Sensor model holding valid=1, color=001, node_id=3; pulse trigger.
  - measure high until valid drops.
  - After model re-asserts valid: tx carries 0x43,0x52,0x33,0x23, 160 cycles total, then msg_done pulse and busy=0.
- color=011, node_id=12 → bytes 0x43,0x42,0x43,0x23.
- color=101, node_id=0 → B1=0x58, B2=0x30.
- Trigger pulses during SEND and in the FINISH cycle → ignored; exactly one message sent, busy never deasserts early.
- Assert rst during bit 5 of B1 → tx=1, busy=0, measure=0 immediately (asynchronously).
  - Next trigger produces a full clean message.
- COLOUR_TIMEOUT_EN defined, valid held 0 after REQ → after 50 cycles message 0x43,0x45,node,0x23 is sent.
  - Undefined: tx stays 1 and busy stays 1 for at least 1000 cycles.
